// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU operation codes and the
// operand-forwarding source select used by the ID/EX stage.
package cpu_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_XOR  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_SRAI = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF,
        FWD_EXMEM,
        FWD_MEMWB
    } fwd_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding mux: picks EX/MEM, then MEM/WB, then register-file data.
// Forwarding paths exist only when ID_EX_FWD_EN is defined; otherwise RF data passes through.
module fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic               exmem_reg_write,
    input  logic [XLEN-1:0]    exmem_data,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic               memwb_reg_write,
    input  logic [XLEN-1:0]    memwb_data,
    output logic [XLEN-1:0]    data
);

`ifdef ID_EX_FWD_EN
    fwd_sel_e sel;

    // x0 is hardwired zero, so a write to it must never be forwarded.
    always_comb begin
        sel = FWD_RF;
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs_addr)
            sel = FWD_EXMEM;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs_addr)
            sel = FWD_MEMWB;
    end

    always_comb begin
        case (sel)
            FWD_EXMEM: data = exmem_data;
            FWD_MEMWB: data = memwb_data;
            default:   data = rf_data;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{rs_addr, exmem_rd, exmem_reg_write, exmem_data,
                          memwb_rd, memwb_reg_write, memwb_data};
    assign data = rf_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding (ID_EX_FWD_EN) and load-use bubble insertion.
// Edge priority: flush > stall > load-use bubble > load.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    rs1_data_i,
    input  logic [XLEN-1:0]    rs2_data_i,
    input  logic [XLEN-1:0]    imm_i,
    input  logic [RADDR_W-1:0] rs1_addr_i,
    input  logic [RADDR_W-1:0] rs2_addr_i,
    input  logic [RADDR_W-1:0] rd_addr_i,
    input  logic [2:0]         alu_ctrl_i,
    input  logic               alu_src_i,
    input  logic               reg_write_i,
    input  logic               mem_read_i,
    input  logic               mem_write_i,
    input  logic               mem_to_reg_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               exmem_reg_write_i,
    input  logic [XLEN-1:0]    exmem_data_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic               memwb_reg_write_i,
    input  logic [XLEN-1:0]    memwb_data_i,
    output logic [XLEN-1:0]    alu_data1_o,
    output logic [XLEN-1:0]    alu_data2_o,
    output logic [2:0]         alu_ctrl_o,
    output logic [XLEN-1:0]    store_data_o,
    output logic [RADDR_W-1:0] rd_addr_o,
    output logic               reg_write_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               mem_to_reg_o,
    output logic               valid_o,
    output logic               hazard_o
);

    logic [RADDR_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]    rs1_data, rs2_data, imm;
    logic               alu_src;
    logic [XLEN-1:0]    fwd1, fwd2;
    logic               bubble, load;

    assign hazard_o = valid_o && mem_read_o && valid_i && rd_addr_o != '0 &&
                      (rd_addr_o == rs1_addr_i || rd_addr_o == rs2_addr_i);

    assign bubble = flush_i || (!stall_i && hazard_o);
    assign load   = !flush_i && !stall_i && !hazard_o;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i || bubble) begin
            if (!rst_i || bubble) begin
                valid_o      <= 1'b0;
                reg_write_o  <= 1'b0;
                mem_read_o   <= 1'b0;
                mem_write_o  <= 1'b0;
                mem_to_reg_o <= 1'b0;
                alu_ctrl_o   <= 3'b000;
                alu_src      <= 1'b0;
                rd_addr_o    <= '0;
                rs1_addr     <= '0;
                rs2_addr     <= '0;
                rs1_data     <= '0;
                rs2_data     <= '0;
                imm          <= '0;
            end
        end else if (load) begin
            valid_o      <= valid_i;
            reg_write_o  <= valid_i & reg_write_i;
            mem_read_o   <= valid_i & mem_read_i;
            mem_write_o  <= valid_i & mem_write_i;
            mem_to_reg_o <= valid_i & mem_to_reg_i;
            alu_ctrl_o   <= alu_ctrl_i;
            alu_src      <= alu_src_i;
            rd_addr_o    <= rd_addr_i;
            rs1_addr     <= rs1_addr_i;
            rs2_addr     <= rs2_addr_i;
            rs1_data     <= rs1_data_i;
            rs2_data     <= rs2_data_i;
            imm          <= imm_i;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd1 (
        .rs_addr         (rs1_addr),
        .rf_data         (rs1_data),
        .exmem_rd        (exmem_rd_i),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_data      (exmem_data_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_data      (memwb_data_i),
        .data            (fwd1)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd2 (
        .rs_addr         (rs2_addr),
        .rf_data         (rs2_data),
        .exmem_rd        (exmem_rd_i),
        .exmem_reg_write (exmem_reg_write_i),
        .exmem_data      (exmem_data_i),
        .memwb_rd        (memwb_rd_i),
        .memwb_reg_write (memwb_reg_write_i),
        .memwb_data      (memwb_data_i),
        .data            (fwd2)
    );

    // SRAI shamt travels in imm unmodified; the ALU ignores the upper bits.
    assign alu_data1_o  = fwd1;
    assign alu_data2_o  = alu_src ? imm : fwd2;
    assign store_data_o = fwd2;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register plus operand-select logic sitting directly upstream of the EX-stage ALU.
- Latches decoded instruction fields and control bits, applies EX/MEM and MEM/WB forwarding, and drives the ALU's data1/data2/ALUCtrl inputs.
- Also detects load-use hazards and self-inserts the required bubble.

Parameters:
- XLEN, 32, datapath width (ALU operands).
- RADDR_W, 5, register-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- valid_i  in  1  decode stage presents an instruction.
- stall_i  in  1  hold current contents (downstream stall).
- flush_i  in  1  squash: load a bubble.
- rs1_data_i / rs2_data_i  in  XLEN  register-file read data.
- imm_i  in  XLEN  sign-extended immediate.
- rs1_addr_i / rs2_addr_i / rd_addr_i  in  RADDR_W  register indices.
- alu_ctrl_i  in  3  ALU operation code.
- alu_src_i  in  1  1 = operand 2 from immediate.
- reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i  in  1 each  control bits.
- exmem_rd_i  in  RADDR_W,  exmem_reg_write_i  in  1,  exmem_data_i  in  XLEN  EX/MEM forward source.
- memwb_rd_i  in  RADDR_W,  memwb_reg_write_i  in  1,  memwb_data_i  in  XLEN  MEM/WB forward source.
- alu_data1_o / alu_data2_o  out  XLEN  ALU operands.
- alu_ctrl_o  out  3  ALU operation code.
- store_data_o  out  XLEN  forwarded rs2 for stores.
- rd_addr_o  out  RADDR_W.
- reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o  out  1 each.
- hazard_o  out  1  load-use stall request to PC/IF-ID.

Behaviour:
- Reset (rst_i low, async): all registered fields 0. valid_o=0, control outputs 0, alu_ctrl_o=3'b000, rd_addr_o=0. Operand outputs are then 0 or a forwarded value.
- Latency: one cycle; fields presented at edge N appear on outputs after edge N.
- Per-edge priority: flush_i > stall_i > hazard bubble > load.
  - Flush: valid and all control bits cleared; data fields don't-care (cleared to 0).
  - Stall: all registers hold.
  - Hazard bubble (hazard_o=1 and no stall): load a bubble.
  - Load: latch all inputs; valid_o <= valid_i. When valid_i=0, control bits are cleared.
- hazard_o is combinational and asserted when all of: valid_o & mem_read_o & valid_i & rd_addr_o!=0 & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i).
- Forwarding (combinational, per operand, on registered rs addr). Forward path into fwd1/fwd2:
  - EX/MEM when exmem_reg_write_i & exmem_rd_i!=0 & match.
  - Else MEM/WB when memwb_reg_write_i & memwb_rd_i!=0 & match.
  - Else registered register-file data.
  - EX/MEM wins when both match. x0 is never forwarded.
- Operand outputs:
  - alu_data1_o = fwd1.
  - alu_data2_o = alu_src ? imm : fwd2.
  - store_data_o = fwd2 always.
- Codes passed unchanged: AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111.
- For SRAI, imm carries shamt; upper bits are passed unmodified.
- Bubble: valid_o=0 and reg_write/mem_* = 0, so downstream has no side effects.

Optional Feature:
- Macro ID_EX_FWD_EN.
  - Defined: forwarding muxes as above.
  - Undefined: fwd1/fwd2 are the registered rs1/rs2 data; forward ports are ignored. Software/NOP insertion handles RAW hazards. hazard_o is still active.

Decomposition:
- Shared package cpu_pkg:
  - ALU code constants (ALU_AND..ALU_SRAI, 3-bit).
  - XLEN and RADDR_W defaults.
  - Forward-select enum: FWD_RF, FWD_EXMEM, FWD_MEMWB.
- One natural sub-module, fwd_mux, instantiated twice. It takes the register address, RF data, and both forward sources, and returns the selected value.

Test Plan:
- Reset mid-operation: load ADD (rd=3, reg_write=1), drop rst_i between edges -> valid_o=0 and reg_write_o=0 immediately, with no clock.
- Forwarding: latched rs1=5, rs1_data=1; exmem_rd=5, exmem_data=0x10; memwb_rd=5, memwb_data=0x20 -> alu_data1_o=0x10. With EX/MEM write disabled -> 0x20. With rs1=0 and both rd=0 -> 1.
- Immediate: ADDI, alu_src=1, imm=0xFFFFFFFF, rs2 forwarded to 7 -> alu_data2_o=0xFFFFFFFF, store_data_o=7.
- Load-use: latched LW rd=4, decode rs2=4 -> hazard_o=1 -> next edge valid_o=0, control 0. Following cycle with the instruction reloaded -> hazard_o=0.
- Stall/flush: stall_i=1 holds outputs for 3 cycles unchanged. stall_i=1 together with flush_i=1 -> bubble.
- Macro off: same stimulus as the forwarding test -> alu_data1_o=1.
